uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the BLE command link: it turns the 8N1 UART stream on `RX` (19200 baud, 50 MHz `clk`) into bytes, and is the receiving end of the `UART_tx` used as the host model. It feeds received command bytes (e.g. 8'h67 'g' start, 8'h73 's' stop) to the command/authorization logic. It runs a 2-flop input synchronizer and a baud/bit-count FSM, and signals each new byte with a level `rdy` flag that the consumer clears.

## Interface
- `BAUD_DIV`, 2604: clocks per bit (50 MHz / 19200); must be ≥ 16.
- `HALF_DIV`, `BAUD_DIV/2` (1302): clocks from start-edge detect to the start-bit mid-sample.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `RX`  in  1  asynchronous serial line, idle high.
- `clr_rdy`  in  1  consumer acknowledge; clears `rdy`.
- `rx_data`  out  8  last good byte, LSB received first.
- `rdy`  out  1  level flag: `rx_data` holds an unread byte.
- `frm_err`  out  1  one-cycle pulse: stop bit sampled low.

## Operation
- **Synchronizer.** `RX` passes through 2 flops (`rx_s`), then 1 history flop. All three reset to 1. A start edge is `rx_s == 0` while the history flop is 1.
- **IDLE.** Baud counter is held at 0. On a start edge: go to START and clear `rdy`.
- **START.** Count to `HALF_DIV`-1, then sample.
  - Sample 1 (false start): return to IDLE; `rdy` stays cleared.
  - Sample 0: go to DATA with bit count 0.
- **DATA.** Every `BAUD_DIV` clocks, sample `rx_s` and right-shift it into the shift register MSB.
  - This repeats for 8 bits; bit count wraps from 7 to STOP.
- **STOP.** Sample after `BAUD_DIV` clocks.
  - Sample 1: load `rx_data` from the shift register and set `rdy`.
  - Sample 0: pulse `frm_err`; leave `rx_data` and `rdy` unchanged.
  - Either way, go to IDLE.
- **`rdy`.**
  - Cleared by `clr_rdy` or by a start edge.
  - If the set (good stop) and `clr_rdy` occur in the same cycle, the set wins.
- **Line held low.** A line stuck low after a framing error cannot retrigger: a new frame requires a 1→0 transition.
- **Width rules.** Baud counter is `$clog2(BAUD_DIV)` bits; bit counter is 3 bits; shift register is 8 bits.

## Timing
- **Reset values.** `rx_data` = 8'h00, `rdy` = 0, `frm_err` = 0, state IDLE, counters 0.
- **Reset mid-frame.** Abort to IDLE; no `rdy` and no `frm_err` from the partial frame.
- **Sample points.** Let cycle E be the cycle the start edge is detected (2 cycles after `RX` falls).
  - Start-bit sample: E + `HALF_DIV`.
  - Data bit k (k = 0..7): E + `HALF_DIV` + (k+1)·`BAUD_DIV`.
  - Stop bit: E + `HALF_DIV` + 9·`BAUD_DIV`.
- **Output latency.** `rx_data`/`rdy` (or `frm_err`) become visible in the cycle after the stop sample: E + 24739 cycles at defaults.
- **Back-to-back frames.** The receiver is in IDLE from the cycle after the stop sample, so a start edge arriving half a bit later is accepted.

## Structure
- **Package `uart_pkg`.**
  - `typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;`
  - Localparam `UART_BAUD_DIV_DEF` = 2604, shared with `UART_tx`.
- **Sub-module `uart_rx_sync`.** Holds the 2-flop synchronizer and history flop. Outputs are `rx_s` and `fall`.
- **Top level.** FSM, baud/bit counters, shift register and output registers.

## Test plan
- **Single byte.** `UART_tx` sends 8'h5A.
  - Expect `rdy` rising at E+24739 ±2 cycles and `rx_data` = 8'h5A.
  - Pulse `clr_rdy` → `rdy` = 0 the next cycle; `rx_data` holds.
- **Back-to-back commands.** Send 8'h67 then 8'h73 without clearing.
  - Expect `rdy` to drop at the second start edge, then reassert with `rx_data` = 8'h73.
  - `frm_err` never asserts.
- **Glitch.** Drive `RX` low for 500 cycles, then high.
  - Expect a return to IDLE, `rdy` staying 0, and `rx_data` unchanged.
- **Framing error.** Send 8'hA5 with the stop bit forced low.
  - Expect one `frm_err` pulse, no `rdy`, and `rx_data` still equal to the prior byte.
  - Hold `RX` low for 10 more bit times → no further `frm_err`.
- **Simultaneous set/clear.** Assert `clr_rdy` in exactly the stop-load cycle → `rdy` = 1.
- **Reset mid-frame.** Assert `rst` for 1 cycle during data bit 4 of 8'hFF.
  - Expect all outputs 0 and no `rdy`.
  - The next frame 8'h3C is then received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the default baud divisor
// used by both the receiver and the UART_tx host model.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int UART_BAUD_DIV_DEF = 2604;
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop metastability synchronizer for the asynchronous RX line plus a
// history flop for falling-edge (start bit) detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic meta;
  logic hist;

  // All flops reset to the idle line level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
      hist <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
      hist <= rx_s;
    end
  end

  assign fall = hist & ~rx_s;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling via a baud counter,
// and a level rdy flag that the consumer clears with clr_rdy.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = UART_BAUD_DIV_DEF,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);
  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  logic             rx_s;
  logic             fall;
  rx_state_t        state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       rx_data_nxt;
  logic             rdy_nxt;
  logic             frm_err_nxt;

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (RX),
    .rx_s (rx_s),
    .fall (fall)
  );

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt + CNT_W'(1);
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift;
    rx_data_nxt  = rx_data;
    frm_err_nxt  = 1'b0;
    // Clear first so a good-stop set later in this block takes priority.
    rdy_nxt      = clr_rdy ? 1'b0 : rdy;

    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        if (fall) begin
          state_nxt = START;
          rdy_nxt   = 1'b0;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_cnt_nxt = '0;
          bit_cnt_nxt  = 3'd0;
          state_nxt    = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_nxt = '0;
          shift_nxt    = {rx_s, shift[7:1]};
          bit_cnt_nxt  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_nxt = '0;
          state_nxt    = IDLE;
          if (rx_s) begin
            rx_data_nxt = shift;
            rdy_nxt     = 1'b1;
          end else begin
            frm_err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      rx_data  <= 8'h00;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      rx_data  <= rx_data_nxt;
      rdy      <= rdy_nxt;
      frm_err  <= frm_err_nxt;
    end
  end

  // The shift register only carries data, so it needs no reset.
  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a reduced baud divisor; expected bytes and
// their rdy-rise cycles go into a scoreboard queue when each frame is sent.
module tb_uart_rx;
  localparam int B = 32;
  localparam int HALF = 16;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   frm_cnt = 0;
  logic rdy_q = 1'b0;
  exp_t sbq[$];

  uart_rx #(.BAUD_DIV(B), .HALF_DIV(HALF)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bit-level host transmitter; leaves RX at the stop level on return.
  task automatic send(input logic [7:0] d, input logic stop, input bit push);
    int   n;
    exp_t e;
    RX = 1'b0;
    n  = cyc;
    if (push) begin
      e.data = d;
      e.cyc  = n + 2 + HALF + 9 * B + 1;
      sbq.push_back(e);
    end
    wait_cyc(B);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      wait_cyc(B);
    end
    RX = stop;
    wait_cyc(B);
  endtask

  // Scoreboard side: every rdy rise must match the oldest expected byte and cycle.
  always @(negedge clk) begin
    if (rst) begin
      rdy_q <= 1'b0;
    end else begin
      if (frm_err) frm_cnt <= frm_cnt + 1;
      if (rdy && !rdy_q) begin
        if (sbq.size() == 0) begin
          check("unexpected_rdy", 32'(rdy), 32'(0));
        end else begin
          check("rx_data", 32'(rx_data), 32'(sbq[0].data));
          check("rdy_cycle", 32'(cyc), 32'(sbq[0].cyc));
          void'(sbq.pop_front());
        end
      end
      rdy_q <= rdy;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    RX      = 1'b1;
    clr_rdy = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    check("reset_rdy", 32'(rdy), 32'(0));
    check("reset_frm_err", 32'(frm_err), 32'(0));

    // Single byte, then acknowledge
    send(8'h5A, 1'b1, 1'b1);
    check("single_rdy", 32'(rdy), 32'(1));
    check("single_data", 32'(rx_data), 32'h5A);
    clr_rdy = 1'b1;
    wait_cyc(1);
    clr_rdy = 1'b0;
    check("clr_rdy_low", 32'(rdy), 32'(0));
    check("clr_data_hold", 32'(rx_data), 32'h5A);

    // Back-to-back commands without clearing
    send(8'h67, 1'b1, 1'b1);
    check("b2b_first_rdy", 32'(rdy), 32'(1));
    fork
      send(8'h73, 1'b1, 1'b1);
      begin
        wait_cyc(3);
        check("b2b_rdy_drop", 32'(rdy), 32'(0));
      end
    join
    check("b2b_second_rdy", 32'(rdy), 32'(1));
    check("b2b_second_data", 32'(rx_data), 32'h73);
    check("b2b_no_frm_err", 32'(frm_cnt), 32'(0));
    clr_rdy = 1'b1;
    wait_cyc(1);
    clr_rdy = 1'b0;

    // Glitch shorter than half a bit
    wait_cyc(5);
    RX = 1'b0;
    wait_cyc(HALF / 2);
    RX = 1'b1;
    wait_cyc(400);
    check("glitch_rdy", 32'(rdy), 32'(0));
    check("glitch_data", 32'(rx_data), 32'h73);
    check("glitch_frm_err", 32'(frm_cnt), 32'(0));

    // Framing error, line then held low
    send(8'hA5, 1'b0, 1'b0);
    wait_cyc(10 * B);
    RX = 1'b1;
    wait_cyc(10);
    check("frm_err_pulses", 32'(frm_cnt), 32'(1));
    check("frm_rdy", 32'(rdy), 32'(0));
    check("frm_data_hold", 32'(rx_data), 32'h73);

    // clr_rdy in the very cycle the stop bit loads the byte
    fork
      send(8'h96, 1'b1, 1'b1);
      begin
        wait_cyc(2 + HALF + 9 * B);
        clr_rdy = 1'b1;
        wait_cyc(1);
        clr_rdy = 1'b0;
        check("set_wins_rdy", 32'(rdy), 32'(1));
        check("set_wins_data", 32'(rx_data), 32'h96);
      end
    join
    clr_rdy = 1'b1;
    wait_cyc(1);
    clr_rdy = 1'b0;

    // Reset during data bit 4
    wait_cyc(5);
    fork
      send(8'hFF, 1'b1, 1'b0);
      begin
        wait_cyc(2 + HALF + 5 * B - 8);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_rdy", 32'(rdy), 32'(0));
        check("midrst_frm_err", 32'(frm_err), 32'(0));
      end
    join
    wait_cyc(2 * B);
    check("midrst_no_rdy", 32'(rdy), 32'(0));
    check("midrst_no_frm", 32'(frm_cnt), 32'(1));

    send(8'h3C, 1'b1, 1'b1);
    wait_cyc(5);
    check("after_rst_rdy", 32'(rdy), 32'(1));
    check("after_rst_data", 32'(rx_data), 32'h3C);
    check("scoreboard_empty", 32'(sbq.size()), 32'(0));
    check("final_frm_cnt", 32'(frm_cnt), 32'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
